// File: rtl/datapath_pkg.sv
// datapath_pkg: widths and phase schedule shared by the phase-gated datapath stages
package datapath_pkg;
   localparam int DATA_W   = 32;
   localparam int NREGS    = 32;
   localparam int AW       = $clog2(NREGS);
   localparam int PHASES   = 10;
   localparam int RD_PHASE = 2;
   localparam int WB_PHASE = 6;
endpackage

// File: rtl/register_file_wb_if.sv
// register_file_wb_if: read/writeback port bundle of the register file
interface register_file_wb_if #(
   parameter int DATA_W = datapath_pkg::DATA_W,
   parameter int AW     = datapath_pkg::AW
);
   logic              regWrite;
   logic [AW-1:0]     readReg1;
   logic [AW-1:0]     readReg2;
   logic [AW-1:0]     writeReg;
   logic [DATA_W-1:0] writeData;
   logic [DATA_W-1:0] readData1;
   logic [DATA_W-1:0] readData2;
   logic              writeDone;
   modport master (output regWrite, readReg1, readReg2, writeReg, writeData,
                   input  readData1, readData2, writeDone);
   modport slave  (input  regWrite, readReg1, readReg2, writeReg, writeData,
                   output readData1, readData2, writeDone);
endinterface

// File: rtl/phase_counter.sv
// phase_counter: free-running 0..PHASES-1 instruction phase, cleared by reset
module phase_counter #(
   parameter int  PHASES = datapath_pkg::PHASES,
   localparam int PW     = $clog2(PHASES)
) (
   input  logic          clock,
   input  logic          reset,
   output logic [PW-1:0] phase
);
   logic [PW-1:0] phase_q, phase_d;
   always_comb phase_d = (phase_q == PW'(PHASES - 1)) ? '0 : phase_q + 1'b1;
   always_ff @(posedge clock) begin
      if (reset) phase_q <= '0;
      else       phase_q <= phase_d;
   end
   assign phase = phase_q;
endmodule

// File: rtl/register_file_wb.sv
// register_file_wb: phase-gated register file; reads sample at RD_PHASE, writeback commits at WB_PHASE
module register_file_wb #(
   parameter int  DATA_W   = datapath_pkg::DATA_W,
   parameter int  NREGS    = datapath_pkg::NREGS,
   parameter int  PHASES   = datapath_pkg::PHASES,
   parameter int  RD_PHASE = datapath_pkg::RD_PHASE,
   parameter int  WB_PHASE = datapath_pkg::WB_PHASE,
   localparam int PW       = $clog2(PHASES)
) (
   input logic               clock,
   input logic               reset,
   register_file_wb_if.slave bus
);
   logic [PW-1:0]     phase;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [DATA_W-1:0] read_data1_q, read_data1_d, read_data2_q, read_data2_d;
   logic              write_done_q, write_done_d;
   logic              rd_en, wb_en;
   phase_counter #(.PHASES(PHASES)) u_phase (
      .clock (clock),
      .reset (reset),
      .phase (phase)
   );
   // register 0 is never written, so it stays at its reset value of 0
   always_comb begin
      rd_en        = phase == PW'(RD_PHASE);
      wb_en        = phase == PW'(WB_PHASE) && bus.regWrite && bus.writeReg != '0;
      regs_d       = regs_q;
      if (wb_en) regs_d[bus.writeReg] = bus.writeData;
      read_data1_d = rd_en ? regs_q[bus.readReg1] : read_data1_q;
      read_data2_d = rd_en ? regs_q[bus.readReg2] : read_data2_q;
      write_done_d = wb_en;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         regs_q       <= '{default: '0};
         read_data1_q <= '0;
         read_data2_q <= '0;
         write_done_q <= 1'b0;
      end else begin
         regs_q       <= regs_d;
         read_data1_q <= read_data1_d;
         read_data2_q <= read_data2_d;
         write_done_q <= write_done_d;
      end
   end
   assign bus.readData1 = read_data1_q;
   assign bus.readData2 = read_data2_q;
   assign bus.writeDone = write_done_q;
endmodule

// File: tb/tb_register_file_wb.sv
// tb_register_file_wb: directed checks of phase-gated reads, writeback and reset behaviour
module tb_register_file_wb;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   compared = 0;
   int   mismatched = 0;
   int   ph = 0;

   register_file_wb_if bus ();

   register_file_wb dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // expected phase seen at the next rising edge
   always @(posedge clock) ph <= reset ? 0 : (ph == 9 ? 0 : ph + 1);

   task automatic goto_phase(input int p);
      @(negedge clock);
      for (int i = 0; i < 12 && ph != p; i++) @(negedge clock);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_bus();
      bus.regWrite  = 1'b0;
      bus.writeReg  = '0;
      bus.writeData = '0;
   endtask

   task automatic do_write(input logic [4:0] r, input logic [31:0] d, output logic done);
      goto_phase(6);
      bus.regWrite  = 1'b1;
      bus.writeReg  = r;
      bus.writeData = d;
      step();
      done = bus.writeDone;
      @(negedge clock);
      idle_bus();
   endtask

   task automatic test_reset();
      logic seen = 1'b0;
      idle_bus();
      bus.readReg1 = 5'd0;
      bus.readReg2 = 5'd0;
      reset = 1'b1;
      repeat (2) step();
      @(negedge clock);
      reset = 1'b0;
      compared++;
      if (dut.phase !== 4'd0) begin
         mismatched++;
         $display("FAIL reset_phase: got %0d want 0", dut.phase);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.writeDone !== 1'b0) seen = 1'b1;
      end
      compared++;
      if (seen !== 1'b0) begin
         mismatched++;
         $display("FAIL idle_write_done: writeDone asserted during idle, want never");
      end
      compared++;
      if (bus.readData1 !== 32'd0 || bus.readData2 !== 32'd0) begin
         mismatched++;
         $display("FAIL idle_read: got %h/%h want 0/0", bus.readData1, bus.readData2);
      end
   endtask

   task automatic test_write();
      logic done;
      do_write(5'd8, 32'h0000_00AB, done);
      compared++;
      if (done !== 1'b1) begin
         mismatched++;
         $display("FAIL write_done_pulse: got %b want 1", done);
      end
      bus.readReg1 = 5'd8;
      #1;
      step();
      compared++;
      if (bus.writeDone !== 1'b0) begin
         mismatched++;
         $display("FAIL write_done_width: got %b want 0", bus.writeDone);
      end
      goto_phase(2);
      compared++;
      if (bus.readData1 !== 32'd0) begin
         mismatched++;
         $display("FAIL read_hold: got %h want 0", bus.readData1);
      end
      step();
      compared++;
      if (bus.readData1 !== 32'h0000_00AB) begin
         mismatched++;
         $display("FAIL read_after_write: got %h want 000000ab", bus.readData1);
      end
   endtask

   task automatic test_write_zero();
      logic done;
      do_write(5'd0, 32'hFFFF_FFFF, done);
      compared++;
      if (done !== 1'b0) begin
         mismatched++;
         $display("FAIL r0_write_done: got %b want 0", done);
      end
      bus.readReg1 = 5'd0;
      bus.readReg2 = 5'd8;
      goto_phase(2);
      step();
      compared++;
      if (bus.readData1 !== 32'd0 || bus.readData2 !== 32'h0000_00AB) begin
         mismatched++;
         $display("FAIL r0_read: got %h/%h want 0/000000ab", bus.readData1, bus.readData2);
      end
   endtask

   task automatic test_wrong_phase();
      logic seen = 1'b0;
      goto_phase(3);
      bus.regWrite  = 1'b1;
      bus.writeReg  = 5'd9;
      bus.writeData = 32'h1234;
      step();
      @(negedge clock);
      idle_bus();
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.writeDone !== 1'b0) seen = 1'b1;
      end
      compared++;
      if (seen !== 1'b0) begin
         mismatched++;
         $display("FAIL off_phase_done: writeDone asserted, want never");
      end
      bus.readReg1 = 5'd9;
      goto_phase(2);
      step();
      compared++;
      if (bus.readData1 !== 32'd0) begin
         mismatched++;
         $display("FAIL off_phase_write: got %h want 0", bus.readData1);
      end
   endtask

   task automatic test_same_addr();
      logic done;
      do_write(5'd5, 32'h55, done);
      bus.readReg1 = 5'd5;
      bus.readReg2 = 5'd5;
      goto_phase(2);
      step();
      compared++;
      if (bus.readData1 !== 32'h55 || bus.readData2 !== 32'h55) begin
         mismatched++;
         $display("FAIL same_addr: got %h/%h want 55/55", bus.readData1, bus.readData2);
      end
   endtask

   task automatic test_back_to_back();
      logic d1, d2;
      do_write(5'd3, 32'h1111_0003, d1);
      do_write(5'd31, 32'hDEAD_BEEF, d2);
      compared++;
      if (d1 !== 1'b1 || d2 !== 1'b1) begin
         mismatched++;
         $display("FAIL b2b_done: got %b/%b want 1/1", d1, d2);
      end
      bus.readReg1 = 5'd3;
      bus.readReg2 = 5'd31;
      goto_phase(2);
      step();
      compared++;
      if (bus.readData1 !== 32'h1111_0003 || bus.readData2 !== 32'hDEAD_BEEF) begin
         mismatched++;
         $display("FAIL b2b_read: got %h/%h want 11110003/deadbeef", bus.readData1, bus.readData2);
      end
   endtask

   task automatic test_reset_abort();
      goto_phase(6);
      bus.regWrite  = 1'b1;
      bus.writeReg  = 5'd6;
      bus.writeData = 32'h77;
      reset = 1'b1;
      step();
      compared++;
      if (bus.writeDone !== 1'b0 || dut.phase !== 4'd0) begin
         mismatched++;
         $display("FAIL abort_reset: done=%b phase=%0d want 0/0", bus.writeDone, dut.phase);
      end
      compared++;
      if (bus.readData1 !== 32'd0 || bus.readData2 !== 32'd0) begin
         mismatched++;
         $display("FAIL abort_outputs: got %h/%h want 0/0", bus.readData1, bus.readData2);
      end
      @(negedge clock);
      reset = 1'b0;
      idle_bus();
      bus.readReg1 = 5'd5;
      bus.readReg2 = 5'd6;
      step();
      compared++;
      if (dut.phase !== 4'd1) begin
         mismatched++;
         $display("FAIL restart_phase: got %0d want 1", dut.phase);
      end
      repeat (2) step();
      compared++;
      if (bus.readData1 !== 32'd0 || bus.readData2 !== 32'd0) begin
         mismatched++;
         $display("FAIL abort_regs: got %h/%h want 0/0", bus.readData1, bus.readData2);
      end
      bus.readReg1 = 5'd31;
      goto_phase(2);
      step();
      compared++;
      if (bus.readData1 !== 32'd0) begin
         mismatched++;
         $display("FAIL reset_clears_regs: got %h want 0", bus.readData1);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_write_zero();
      test_wrong_phase();
      test_same_addr();
      test_back_to_back();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
